// File: rtl/led_walk_checker.sv
// Receive-side checker for an 8-bit walking one-hot bus: acquires lock, tracks position, counts violations.
// Optional macro LED_WALK_CHECK_REVERSE_EN: walk direction is learned in ACQUIRE and enforced while LOCKED.
module led_walk_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W      = 8,
  parameter int ALLOW_HOLD = 1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [7:0]       i_led,
  input  logic             i_sample,
  output logic             o_locked,
  output logic [2:0]       o_index,
  output logic             o_error,
  output logic [ERR_W-1:0] o_err_count,
  output logic             o_onehot_ok
);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam logic [3:0]       LOCK_CNT = 4'(LOCK_COUNT);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

  function automatic logic is_onehot(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return (n == 4'd1);
  endfunction

  function automatic logic [2:0] onehot_pos(input logic [7:0] v);
    logic [2:0] p;
    p = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        p = 3'(i);
      end else begin
        p = p;
      end
    end
    return p;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [2:0]       index_q, index_d;
  logic [3:0]       count_q, count_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             onehot_q, onehot_d;
  logic             locked_q, locked_d;

  logic       onehot_s;
  logic [2:0] pos_s;
  logic [2:0] up_s;
  logic       hold_s;
  logic       fwd_s;
  logic       adv_s;

  assign onehot_s = is_onehot(i_led);
  assign pos_s    = onehot_pos(i_led);
  assign up_s     = index_q + 3'd1;
  assign hold_s   = (ALLOW_HOLD != 0) && (pos_s == index_q);

`ifdef LED_WALK_CHECK_REVERSE_EN
  logic       dir_q, dir_d;
  logic [2:0] dn_s;
  assign dn_s  = index_q - 3'd1;
  assign fwd_s = dir_q ? (pos_s == dn_s) : (pos_s == up_s);
  // The first advance after a (re)seed may go either way and fixes the direction.
  assign adv_s = (count_q == 4'd0) ? ((pos_s == up_s) || (pos_s == dn_s)) : fwd_s;
`else
  assign fwd_s = (pos_s == up_s);
  assign adv_s = fwd_s;
`endif

  // Next-state logic for the search/acquire/locked tracker.
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    count_d   = count_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    onehot_d  = onehot_q;
    locked_d  = locked_q;
`ifdef LED_WALK_CHECK_REVERSE_EN
    dir_d     = dir_q;
`endif
    if (i_sample) begin
      onehot_d = onehot_s;
      case (state_q)
        ST_SEARCH: begin
          if (onehot_s) begin
            index_d = pos_s;
            count_d = 4'd0;
            state_d = ST_ACQUIRE;
          end else begin
            state_d = ST_SEARCH;
          end
        end
        ST_ACQUIRE: begin
          if (!onehot_s) begin
            state_d = ST_SEARCH;
            count_d = 4'd0;
          end else if (hold_s) begin
            count_d = count_q;
          end else if (adv_s) begin
            index_d = pos_s;
            count_d = count_q + 4'd1;
`ifdef LED_WALK_CHECK_REVERSE_EN
            if (count_q == 4'd0) begin
              dir_d = (pos_s == dn_s);
            end else begin
              dir_d = dir_q;
            end
`endif
            if ((count_q + 4'd1) == LOCK_CNT) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
            end else begin
              state_d  = ST_ACQUIRE;
            end
          end else begin
            index_d = pos_s;
            count_d = 4'd0;
          end
        end
        ST_LOCKED: begin
          if (onehot_s && (hold_s || fwd_s)) begin
            index_d = pos_s;
          end else begin
            // Violation: index keeps the last good position, re-lock needs a full acquire.
            err_d    = 1'b1;
            locked_d = 1'b0;
            state_d  = ST_SEARCH;
            count_d  = 4'd0;
            if (err_cnt_q != ERR_MAX) begin
              err_cnt_d = err_cnt_q + ERR_ONE;
            end else begin
              err_cnt_d = err_cnt_q;
            end
          end
        end
        default: begin
          state_d  = ST_SEARCH;
          locked_d = 1'b0;
          count_d  = 4'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q   <= ST_SEARCH;
      index_q   <= 3'd0;
      count_q   <= 4'd0;
      err_q     <= 1'b0;
      err_cnt_q <= {ERR_W{1'b0}};
      onehot_q  <= 1'b0;
      locked_q  <= 1'b0;
`ifdef LED_WALK_CHECK_REVERSE_EN
      dir_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      count_q   <= count_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      onehot_q  <= onehot_d;
      locked_q  <= locked_d;
`ifdef LED_WALK_CHECK_REVERSE_EN
      dir_q     <= dir_d;
`endif
    end
  end

  assign o_locked    = locked_q;
  assign o_index     = index_q;
  assign o_error     = err_q;
  assign o_err_count = err_cnt_q;
  assign o_onehot_ok = onehot_q;

endmodule

// File: tb/tb_led_walk_checker.sv
// Scoreboard bench for led_walk_checker: two instances (hold allowed / not allowed) against a behavioural model.
module tb_led_walk_checker;

  localparam int LOCK_COUNT = 4;
  localparam int ERR_W      = 8;
  localparam int ERR_SAT    = (1 << ERR_W) - 1;

  typedef struct packed {
    logic       locked;
    logic [2:0] idx;
    logic       err;
    logic [7:0] ecnt;
    logic       oh;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] led = 8'h00;
  logic       smp = 1'b0;

  logic       lk [2];
  logic [2:0] ix [2];
  logic       er [2];
  logic [7:0] ec [2];
  logic       ok [2];

  int n_tests = 0;
  int n_fail  = 0;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  led_walk_checker #(.LOCK_COUNT(LOCK_COUNT), .ERR_W(ERR_W), .ALLOW_HOLD(1)) u_hold (
    .i_clk(clk), .i_reset_n(rst_n), .i_led(led), .i_sample(smp),
    .o_locked(lk[0]), .o_index(ix[0]), .o_error(er[0]), .o_err_count(ec[0]), .o_onehot_ok(ok[0])
  );

  led_walk_checker #(.LOCK_COUNT(LOCK_COUNT), .ERR_W(ERR_W), .ALLOW_HOLD(0)) u_nohold (
    .i_clk(clk), .i_reset_n(rst_n), .i_led(led), .i_sample(smp),
    .o_locked(lk[1]), .o_index(ix[1]), .o_error(er[1]), .o_err_count(ec[1]), .o_onehot_ok(ok[1])
  );

  // Reference model: 0 = searching, 1 = acquiring, 2 = locked
  int m_mode [2];
  int m_idx  [2];
  int m_cnt  [2];
  int m_ecnt [2];
  bit m_oh   [2];
  bit m_err  [2];
  bit m_dir  [2];
  bit hold_en [2] = '{1'b1, 1'b0};

  function automatic int pos_of(input logic [7:0] v);
    int p = 0;
    for (int i = 0; i < 8; i++) if (v[i]) p = i;
    return p;
  endfunction

  task automatic model_step(input int m, input bit r_n, input bit s, input logic [7:0] v);
    int p;
    bit oh, up, dn, hold, fwd;
    m_err[m] = 1'b0;
    if (!r_n) begin
      m_mode[m] = 0; m_idx[m] = 0; m_cnt[m] = 0; m_ecnt[m] = 0; m_oh[m] = 1'b0; m_dir[m] = 1'b0;
      return;
    end
    if (!s) return;
    oh   = ($countones(v) == 1);
    p    = pos_of(v);
    m_oh[m] = oh;
    up   = (p == (m_idx[m] + 1) % 8);
    dn   = (p == (m_idx[m] + 7) % 8);
    hold = hold_en[m] && (p == m_idx[m]);
`ifdef LED_WALK_CHECK_REVERSE_EN
    fwd  = m_dir[m] ? dn : up;
`else
    fwd  = up;
`endif
    if (m_mode[m] == 0) begin
      if (oh) begin m_idx[m] = p; m_cnt[m] = 0; m_mode[m] = 1; end
    end else if (m_mode[m] == 1) begin
      if (!oh) begin
        m_mode[m] = 0; m_cnt[m] = 0;
      end else if (!hold) begin
`ifdef LED_WALK_CHECK_REVERSE_EN
        if (m_cnt[m] == 0 && (up || dn)) begin m_dir[m] = dn; fwd = 1'b1; end
`endif
        m_idx[m] = p;
        if (fwd) begin
          m_cnt[m]++;
          if (m_cnt[m] == LOCK_COUNT) m_mode[m] = 2;
        end else begin
          m_cnt[m] = 0;
        end
      end
    end else begin
      if (oh && (hold || fwd)) begin
        m_idx[m] = p;
      end else begin
        m_err[m] = 1'b1;
        if (m_ecnt[m] < ERR_SAT) m_ecnt[m]++;
        m_mode[m] = 0; m_cnt[m] = 0;
      end
    end
  endtask

  function automatic exp_t model_out(input int m);
    exp_t e;
    e.locked = (m_mode[m] == 2);
    e.idx    = 3'(m_idx[m]);
    e.err    = m_err[m];
    e.ecnt   = 8'(m_ecnt[m]);
    e.oh     = m_oh[m];
    return e;
  endfunction

  // Issue one stimulus cycle and queue what each instance must show after the next edge.
  task automatic drive(input bit r_n, input bit s, input logic [7:0] v);
    @(negedge clk);
    rst_n = r_n; smp = s; led = v;
    model_step(0, r_n, s, v);
    model_step(1, r_n, s, v);
    q0.push_back(model_out(0));
    q1.push_back(model_out(1));
  endtask

  task automatic walk(input int start, input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 8'(1 << ((start + i) % 8)));
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare(input int m, input exp_t e);
    string tag;
    tag = (m == 0) ? "hold" : "nohold";
    check({tag, ".o_locked"},    int'(lk[m]), int'(e.locked));
    check({tag, ".o_index"},     int'(ix[m]), int'(e.idx));
    check({tag, ".o_error"},     int'(er[m]), int'(e.err));
    check({tag, ".o_err_count"}, int'(ec[m]), int'(e.ecnt));
    check({tag, ".o_onehot_ok"}, int'(ok[m]), int'(e.oh));
  endtask

  // Monitor: one expectation per instance is consumed after each clock edge that follows a stimulus.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin e = q0.pop_front(); compare(0, e); end
      if (q1.size() > 0) begin e = q1.pop_front(); compare(1, e); end
    end
  end

  initial begin
    int wpos;
    int r;
    logic [7:0] v;

    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'hFF);

    // Lock on 01..10, then 20 gives index 5
    walk(0, 6);
    // Wrap 80 -> 01 while locked
    walk(6, 3);
    // Locked at 04, jump to 20
    walk(1, 2);
    drive(1'b1, 1'b1, 8'h20);
    // Re-lock, then zero byte and a two-hot byte
    walk(0, 8);
    drive(1'b1, 1'b1, 8'h00);
    drive(1'b1, 1'b1, 8'h03);
    // Lock at 04, then hold on 08
    walk(6, 5);
    drive(1'b1, 1'b1, 8'h08);
    drive(1'b1, 1'b1, 8'h08);
    drive(1'b1, 1'b1, 8'h10);
    // Strobe low holds everything and suppresses error
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h81);
    drive(1'b1, 1'b1, 8'h20);

    // Drive the error counter into saturation
    for (int k = 0; k < 300; k++) begin
      walk($urandom_range(0, 7), 5);
      drive(1'b1, 1'b1, 8'h00);
    end
    walk(3, 6);
    drive(1'b0, 1'b1, 8'h55);
    walk(0, 6);

    // Randomized walk with holds, garbage, reversals, strobe gaps and rare resets
    wpos = 0;
    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        wpos = (wpos + 1) % 8;
        drive(1'b1, 1'b1, 8'(1 << wpos));
      end else if (r < 78) begin
        drive(1'b1, 1'b1, 8'(1 << wpos));
      end else if (r < 86) begin
        v = 8'($urandom);
        drive(1'b1, 1'b1, v);
      end else if (r < 90) begin
        wpos = (wpos + 7) % 8;
        drive(1'b1, 1'b1, 8'(1 << wpos));
      end else if (r < 98) begin
        v = 8'($urandom);
        drive(1'b1, 1'b0, v);
      end else begin
        drive(1'b0, 1'b1, 8'(1 << wpos));
      end
    end

    @(posedge clk);
    #3;
    check("queue_drained", q0.size() + q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
